// File: rtl/mem_a_skew_pingpong.sv
// mem_a_skew_pingpong
// Double-buffered A-operand memory for the systolic array. A DIM x DIM tile is
// written row by row into the fill bank while the previously committed tile
// streams out of the other bank as diagonally skewed columns. The streaming
// bank is selected by a single bit, so swapping the two banks costs no data
// movement and consecutive tiles stream back to back with no bubble.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   wr_en      write Ain into the fill bank at row wr_row
//   wr_row     row index for the write
//   Ain        row data, Ain[j] = A[wr_row][j]
//   wr_commit  mark the fill bank complete (pending)
//   en         advance the stream; 0 freezes t and the outputs
//   Aout       skewed outputs, Aout[i] = A[i][t-i] when in range, else 0
//   Aout_vld   high while streaming
//   fill_full  fill bank is pending; writes and commits are ignored
//   done       one-cycle pulse when the last tile ends and the block idles
module mem_a_skew_pingpong #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(DIM)-1:0]           wr_row,
  input  logic [DIM-1:0][BITS_AB-1:0]      Ain,
  input  logic                             wr_commit,
  input  logic                             en,
  output logic [DIM-1:0][BITS_AB-1:0]      Aout,
  output logic                             Aout_vld,
  output logic                             fill_full,
  output logic                             done
);

  localparam int RW = $clog2(DIM);
  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] t_reg, t_next;
  logic          pending_reg, pending_next;
  logic          sel_reg, sel_next;   // bank currently streaming; ~sel_reg is the fill bank
  logic          done_next;

  logic [DIM-1:0][BITS_AB-1:0] bank [2][DIM];

  // Next-state logic. A swap only ever happens while pending is set, and a
  // commit is only accepted while pending is clear, so the two never collide.
  always_comb begin
    state_next   = state_reg;
    t_next       = t_reg;
    pending_next = pending_reg;
    sel_next     = sel_reg;
    done_next    = 1'b0;

    if (wr_commit && !pending_reg) begin
      pending_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          sel_next     = ~sel_reg;
          pending_next = 1'b0;
          t_next       = '0;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        if (en) begin
          if (t_reg != T_LAST) begin
            t_next = t_reg + 1'b1;
          end else if (pending_reg) begin
            sel_next     = ~sel_reg;
            pending_next = 1'b0;
            t_next       = '0;
          end else begin
            state_next = IDLE;
            t_next     = '0;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      t_reg       <= '0;
      pending_reg <= 1'b0;
      sel_reg     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t_reg       <= t_next;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      done        <= done_next;
    end
  end

  // Bank storage. Writes are gated by the pending flag as sampled at this
  // edge, so a write in the swap cycle is dropped and the freed bank becomes
  // writable one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DIM; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else if (wr_en && !pending_reg) begin
      bank[~sel_reg][wr_row] <= Ain;
    end
  end

  assign Aout_vld  = (state_reg == STREAM);
  assign fill_full = pending_reg;

  // Skewed read-out. col = t - i is formed one bit wider than t; when t < i
  // the subtraction wraps to a value of at least 4*DIM - DIM + 1, so the
  // single "col < DIM" test rejects both the not-yet-started and the
  // already-finished positions.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_row
      logic [TW:0] col;
      logic        hit;
      assign col = {1'b0, t_reg} - (TW + 1)'(gi);
      assign hit = (state_reg == STREAM) && (col < (TW + 1)'(DIM));
      assign Aout[gi] = hit ? bank[sel_reg][gi][col[RW-1:0]] : '0;
    end
  endgenerate

endmodule
